// File: rtl/vga_pkg.sv
// Shared constants for the VGA page scan-out: 640x480@60 timing defaults,
// derived totals, sync windows and the two legal page codes.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  localparam logic [1:0] PAGE_A = 2'b01;
  localparam logic [1:0] PAGE_B = 2'b10;

  // Only the two one-hot codes select a page; 00 and 11 are glitch/idle codes.
  function automatic logic page_code_valid(input logic [1:0] code);
    return (code == PAGE_A) || (code == PAGE_B);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with active-region and
// sync-window decode. Used once per line (horizontal) and once per frame
// (vertical, advanced by the horizontal wrap).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int W      = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o,
  output logic         active_o,
  output logic         sync_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] cnt_q, cnt_d;

  // Advance when enabled, wrapping to zero after the last position.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Position register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign wrap_o   = en_i && (cnt_q == LAST);
  assign active_o = (cnt_q < ACT_END);
  assign sync_o   = (cnt_q >= SYNC_START) && (cnt_q < SYNC_END);

endmodule

// File: rtl/vga_page_scanout.sv
// VGA raster timing generator with tear-free page selection. The requested
// page is tracked continuously but only takes effect at the frame boundary,
// so a whole frame is always scanned from one page. All outputs are
// registered off the previous cycle's counter values and stay aligned.
module vga_page_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [1:0]       D_SEL,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             DE,
  output logic [CNT_W-1:0] PIX_X,
  output logic [CNT_W-1:0] PIX_Y,
  output logic [1:0]       PAGE,
  output logic             FRAME_START
);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap;
  logic             h_act, v_act;
  logic             h_sync, v_sync;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (CNT_W)
  ) u_h_axis (
    .clk_i    (CLK),
    .rst_n_i  (RST_N),
    .en_i     (1'b1),
    .cnt_o    (h_cnt),
    .wrap_o   (h_wrap),
    .active_o (h_act),
    .sync_o   (h_sync)
  );

  // Vertical axis steps once per line; its wrap marks the last pixel of a frame.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (CNT_W)
  ) u_v_axis (
    .clk_i    (CLK),
    .rst_n_i  (RST_N),
    .en_i     (h_wrap),
    .cnt_o    (v_cnt),
    .wrap_o   (v_wrap),
    .active_o (v_act),
    .sync_o   (v_sync)
  );

  logic [1:0] next_page_q;
  logic [1:0] page_q;
  logic [1:0] page_sel;

  // A valid code arriving on the boundary cycle itself is used directly.
  assign page_sel = page_code_valid(D_SEL) ? D_SEL : next_page_q;

  // Track the latest valid request; commit it to the scan page at frame end.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      next_page_q <= PAGE_A;
      page_q      <= PAGE_A;
    end else begin
      next_page_q <= page_sel;
      if (v_wrap) begin
        page_q <= page_sel;
      end
    end
  end

  logic             de_d;
  logic [CNT_W-1:0] pix_x_d, pix_y_d;
  logic             frame_start_d;

  // Decode the current counter position into next-cycle output values.
  always_comb begin
    de_d          = h_act && v_act;
    pix_x_d       = de_d ? h_cnt : '0;
    pix_y_d       = de_d ? v_cnt : '0;
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
  end

  logic             hsync_q, vsync_q, de_q, frame_start_q;
  logic [CNT_W-1:0] pix_x_q, pix_y_q;
  logic [1:0]       page_out_q;

  // Output registers; page goes through the same stage so it lines up with FRAME_START.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      page_out_q    <= PAGE_A;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= ~h_sync;
      vsync_q       <= ~v_sync;
      de_q          <= de_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      page_out_q    <= page_q;
      frame_start_q <= frame_start_d;
    end
  end

  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DE          = de_q;
  assign PIX_X       = pix_x_q;
  assign PIX_Y       = pix_y_q;
  assign PAGE        = page_out_q;
  assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_page_scanout.sv
// Bench for vga_page_scanout, run with a scaled-down raster (32x19) so
// several whole frames fit in a short run. A reference raster model pushes
// the expected output word each cycle; it is popped and compared one edge later.
module tb_vga_page_scanout;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       CLK;
  logic       RST_N;
  logic [1:0] D_SEL;
  logic       HSYNC, VSYNC, DE, FRAME_START;
  logic [9:0] PIX_X, PIX_Y;
  logic [1:0] PAGE;

  vga_page_scanout #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .D_SEL       (D_SEL),
    .HSYNC       (HSYNC),
    .VSYNC       (VSYNC),
    .DE          (DE),
    .PIX_X       (PIX_X),
    .PIX_Y       (PIX_Y),
    .PAGE        (PAGE),
    .FRAME_START (FRAME_START)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic hs, input logic vs, input logic de,
                                       input logic [9:0] x, input logic [9:0] y,
                                       input logic [1:0] pg, input logic fs);
    return {6'b0, hs, vs, de, x, y, pg, fs};
  endfunction

  function automatic logic [31:0] dut_word();
    return pack(HSYNC, VSYNC, DE, PIX_X, PIX_Y, PAGE, FRAME_START);
  endfunction

  // Reference model and scoreboard
  logic [31:0] exp_q[$];
  int          mh, mv;
  logic [1:0]  m_next, m_cur;

  // Observed-timing trackers
  int   cyc_since_fs, cyc_since_hsf, hs_low, de_run, vs_low;
  bit   fs_seen, hsf_seen;
  logic prev_hs, prev_vs, prev_de;
  logic [1:0] prev_page;

  task automatic reset_model();
    mh = 0; mv = 0;
    m_next = 2'b01; m_cur = 2'b01;
    exp_q.delete();
    cyc_since_fs = 0; cyc_since_hsf = 0; hs_low = 0; de_run = 0; vs_low = 0;
    fs_seen = 0; hsf_seen = 0;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_de = 1'b0; prev_page = 2'b01;
  endtask

  task automatic tick();
    logic e_de, e_hs, e_vs, e_fs;
    logic [9:0] e_x, e_y;
    logic [1:0] sel;
    e_de = (mh < HA) && (mv < VA);
    e_x  = e_de ? 10'(mh) : 10'd0;
    e_y  = e_de ? 10'(mv) : 10'd0;
    e_hs = !((mh >= HA + HF) && (mh < HA + HF + HS));
    e_vs = !((mv >= VA + VF) && (mv < VA + VF + VS));
    e_fs = (mh == 0) && (mv == 0);
    exp_q.push_back(pack(e_hs, e_vs, e_de, e_x, e_y, m_cur, e_fs));

    sel = (D_SEL == 2'b01 || D_SEL == 2'b10) ? D_SEL : m_next;
    if (mh == HT - 1 && mv == VT - 1) m_cur = sel;
    m_next = sel;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end

    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) check_eq("sb_empty", 32'd0, 32'd1);
    else                   check_eq("outs", dut_word(), exp_q.pop_front());

    cyc_since_fs++;
    cyc_since_hsf++;
    if (FRAME_START) begin
      if (fs_seen) check_eq("frame_period", cyc_since_fs, FRAME);
      fs_seen = 1; cyc_since_fs = 0;
    end
    if (prev_hs && !HSYNC) begin
      if (hsf_seen) check_eq("line_period", cyc_since_hsf, HT);
      hsf_seen = 1; cyc_since_hsf = 0;
    end
    if (!HSYNC) hs_low++;
    else if (!prev_hs) begin check_eq("hs_width", hs_low, HS); hs_low = 0; end
    if (DE) de_run++;
    else if (prev_de) begin check_eq("de_width", de_run, HA); de_run = 0; end
    if (prev_vs && !VSYNC && fs_seen) check_eq("vs_start", cyc_since_fs, (VA + VF) * HT);
    if (!VSYNC) vs_low++;
    else if (!prev_vs) begin check_eq("vs_width", vs_low, VS * HT); vs_low = 0; end
    prev_hs = HSYNC; prev_vs = VSYNC; prev_de = DE;
  endtask

  // Tick until FRAME_START is observed; returns the PAGE seen the cycle before.
  task automatic run_to_fs(input int budget, output logic [1:0] page_before);
    bit found = 0;
    page_before = PAGE;
    for (int i = 0; i < budget && !found; i++) begin
      page_before = PAGE;
      tick();
      if (FRAME_START) found = 1;
    end
    if (!found) check_eq("fs_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq(tag, dut_word(), pack(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 2'b01, 1'b0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] pb;
    RST_N = 1'b1;
    D_SEL = 2'b01;
    reset_model();
    #2 RST_N = 1'b0;
    #1 check_reset_outputs("rst_async_first");
    repeat (3) @(posedge CLK);
    #1 check_reset_outputs("rst_hold");
    RST_N = 1'b1;

    // First output cycle after release is pixel (0,0) of page A.
    tick();
    check_eq("first_fs", {31'd0, FRAME_START}, 32'd1);
    check_eq("first_de", {31'd0, DE}, 32'd1);
    repeat (FRAME + 50) tick();

    // Request page B mid-frame: must not appear until the next frame start.
    while (!(mv == 5 && mh == 0)) tick();
    D_SEL = 2'b10;
    run_to_fs(2 * FRAME, pb);
    check_eq("page_hold", pb, 2'b01);
    check_eq("page_switch", PAGE, 2'b10);

    // Invalid codes across a boundary leave page B in place.
    D_SEL = 2'b00;
    repeat (3 * HT) tick();
    D_SEL = 2'b11;
    run_to_fs(2 * FRAME, pb);
    check_eq("page_ignore", PAGE, 2'b10);

    // Valid code present only on the boundary cycle is still taken.
    while (!(mh == HT - 1 && mv == VT - 1)) tick();
    D_SEL = 2'b01;
    tick();
    D_SEL = 2'b11;
    run_to_fs(4, pb);
    check_eq("page_edge_hold", pb, 2'b10);
    check_eq("page_bypass", PAGE, 2'b01);

    // Reset mid-frame, then a full restart with page A despite a B request.
    D_SEL = 2'b10;
    while (!(mv == 7 && mh == 10)) tick();
    RST_N = 1'b0;
    #1 check_reset_outputs("rst_async_mid");
    reset_model();
    repeat (2) @(posedge CLK);
    #1 check_reset_outputs("rst_hold_mid");
    RST_N = 1'b1;
    tick();
    check_eq("restart_fs", {31'd0, FRAME_START}, 32'd1);
    check_eq("restart_page", PAGE, 2'b01);
    run_to_fs(2 * FRAME, pb);
    check_eq("restart_page_hold", pb, 2'b01);
    check_eq("restart_page_switch", PAGE, 2'b10);
    repeat (HT * 2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
